// File: rtl/color_sense_pkg.sv
// ---------------------------------------------------------------------------
// color_sense_pkg
// Shared types and constants for the multi-channel colour sensor sequencer:
//   - state_t   : frame sequencer states
//   - color_t   : published colour codes (0 none, 1 red, 2 green, 3 blue)
//   - filter_t  : s2/s3 filter-select pair, plus one encoding per channel
//   - NUM_CH    : number of measured channels
//   - filter_for(): filter pair driven while the sequencer is in a state
//   - max_int() : constant helper for counter sizing
// ---------------------------------------------------------------------------
package color_sense_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET_R  = 3'd1,
    ST_MEAS_R = 3'd2,
    ST_SET_G  = 3'd3,
    ST_MEAS_G = 3'd4,
    ST_SET_B  = 3'd5,
    ST_MEAS_B = 3'd6,
    ST_DECIDE = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    COLOR_NONE  = 3'd0,
    COLOR_RED   = 3'd1,
    COLOR_GREEN = 3'd2,
    COLOR_BLUE  = 3'd3
  } color_t;

  typedef struct packed {
    logic s2;
    logic s3;
  } filter_t;

  localparam filter_t FILT_RED   = '{s2: 1'b0, s3: 1'b0};
  localparam filter_t FILT_GREEN = '{s2: 1'b1, s3: 1'b1};
  localparam filter_t FILT_BLUE  = '{s2: 1'b0, s3: 1'b1};
  localparam filter_t FILT_CLEAR = '{s2: 1'b1, s3: 1'b0};

  function automatic filter_t filter_for(input state_t st);
    case (st)
      ST_SET_R, ST_MEAS_R: filter_for = FILT_RED;
      ST_SET_G, ST_MEAS_G: filter_for = FILT_GREEN;
      ST_SET_B, ST_MEAS_B: filter_for = FILT_BLUE;
      default:             filter_for = FILT_CLEAR;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// ---------------------------------------------------------------------------
// freq_edge_sync
// Brings the asynchronous sensor frequency output into the clk domain with a
// 2-flop synchroniser and produces a one-cycle pulse per synchronised rising
// edge.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  asynchronous input (sensor c_out)
//   edge_out out one-cycle pulse on each synchronised 0->1 transition
// ---------------------------------------------------------------------------
module freq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic meta;
  logic sync;
  logic sync_d;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign edge_out = sync & ~sync_d;

endmodule

// File: rtl/color_sense_multi.sv
// ---------------------------------------------------------------------------
// color_sense_multi
// Sequences a TCS3200-style colour sensor through red, green and blue
// filters. Each channel gets SETTLE discarded cycles followed by a WINDOW-
// cycle measurement in which synchronised c_out rising edges are counted
// (saturating at 2^CNT_W-1). After blue, one DECIDE cycle picks the in-band
// channel with the highest count (ties to red, then green); results publish
// the following cycle with a one-cycle color_valid strobe.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   en                  start/continue frames, sampled only in IDLE
//   c_out               sensor frequency output (asynchronous)
//   s2, s3              filter selects (idle/clear = 1,0)
//   color               0 none, 1 red, 2 green, 3 blue; held between frames
//   color_valid         one-cycle pulse when color/counts update
//   r/g/b_count         counts of the last completed frame
//   sat                 some channel saturated in the last frame
//
// Build option: define COLOR_SENSE_HYST_EN to only let a classification
// reach color when two consecutive frames agree on it.
// ---------------------------------------------------------------------------
module color_sense_multi
  import color_sense_pkg::*;
#(
  parameter int WINDOW = 300,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 9,
  parameter int R_LO   = 25,
  parameter int R_HI   = 120,
  parameter int G_LO   = 25,
  parameter int G_HI   = 120,
  parameter int B_LO   = 25,
  parameter int B_HI   = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             c_out,
  output logic             s2,
  output logic             s3,
  output logic [2:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] r_count,
  output logic [CNT_W-1:0] g_count,
  output logic [CNT_W-1:0] b_count,
  output logic             sat
);

  localparam int WC_W = $clog2(max_int(WINDOW, SETTLE) + 1);
  localparam logic [WC_W-1:0]  SETTLE_LAST = WC_W'(SETTLE - 1);
  localparam logic [WC_W-1:0]  WINDOW_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WC_W-1:0]  wcnt;
  logic [WC_W-1:0]  wcnt_nxt;
  logic [CNT_W-1:0] ecnt;
  logic [CNT_W-1:0] ecnt_nxt;
  logic [CNT_W-1:0] ecnt_add;
  logic             ovf;
  logic             sat_acc;
  logic             sat_acc_nxt;
  logic [CNT_W-1:0] stage_r;
  logic [CNT_W-1:0] stage_g;
  logic [CNT_W-1:0] stage_b;
  filter_t          filt;
  color_t           color_q;
  color_t           dec_color;
  logic [CNT_W-1:0] best_cnt;
  logic             in_set;
  logic             in_meas;
  logic             phase_last;
  logic             edge_pulse;
`ifdef COLOR_SENSE_HYST_EN
  color_t           prev_raw;
`endif

  freq_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (c_out),
    .edge_out (edge_pulse)
  );

  function automatic logic in_band(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return (int'(c) > lo) && (int'(c) < hi);
  endfunction

  assign in_set     = (state == ST_SET_R) || (state == ST_SET_G) || (state == ST_SET_B);
  assign in_meas    = (state == ST_MEAS_R) || (state == ST_MEAS_G) || (state == ST_MEAS_B);
  assign phase_last = in_set ? (wcnt == SETTLE_LAST) : (wcnt == WINDOW_LAST);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (en) state_nxt = ST_SET_R;
      ST_SET_R:  if (phase_last) state_nxt = ST_MEAS_R;
      ST_MEAS_R: if (phase_last) state_nxt = ST_SET_G;
      ST_SET_G:  if (phase_last) state_nxt = ST_MEAS_G;
      ST_MEAS_G: if (phase_last) state_nxt = ST_SET_B;
      ST_SET_B:  if (phase_last) state_nxt = ST_MEAS_B;
      ST_MEAS_B: if (phase_last) state_nxt = ST_DECIDE;
      ST_DECIDE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Window counter runs 0..SETTLE-1 or 0..WINDOW-1 inside a phase and is
  // parked at zero elsewhere; it never wraps on its own.
  always_comb begin
    wcnt_nxt = '0;
    if ((in_set || in_meas) && !phase_last) wcnt_nxt = wcnt + 1'b1;
  end

  // Edge counter: only advances while measuring, clamps at all-ones and flags
  // the dropped edge. ecnt_add already includes an edge seen on the last
  // measurement cycle, which is what gets staged.
  always_comb begin
    ecnt_add = ecnt;
    ovf      = 1'b0;
    if (in_meas && edge_pulse) begin
      if (ecnt == CNT_MAX) ovf = 1'b1;
      else                 ecnt_add = ecnt + 1'b1;
    end
    ecnt_nxt    = (in_meas && !phase_last) ? ecnt_add : '0;
    sat_acc_nxt = (state == ST_IDLE) ? 1'b0 : (sat_acc | ovf);
  end

  // Best in-band channel; strict '>' keeps the earlier (lower-code) channel
  // on ties.
  always_comb begin
    dec_color = COLOR_NONE;
    best_cnt  = '0;
    if (in_band(stage_r, R_LO, R_HI)) begin
      dec_color = COLOR_RED;
      best_cnt  = stage_r;
    end
    if (in_band(stage_g, G_LO, G_HI) && (dec_color == COLOR_NONE || stage_g > best_cnt)) begin
      dec_color = COLOR_GREEN;
      best_cnt  = stage_g;
    end
    if (in_band(stage_b, B_LO, B_HI) && (dec_color == COLOR_NONE || stage_b > best_cnt)) begin
      dec_color = COLOR_BLUE;
      best_cnt  = stage_b;
    end
  end

  // NOTE: the three staging registers are reset along with everything else;
  // they are a handful of flops, not a RAM, so the reset costs nothing and
  // keeps DECIDE deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      ecnt        <= '0;
      sat_acc     <= 1'b0;
      stage_r     <= '0;
      stage_g     <= '0;
      stage_b     <= '0;
      filt        <= FILT_CLEAR;
      color_q     <= COLOR_NONE;
      color_valid <= 1'b0;
      r_count     <= '0;
      g_count     <= '0;
      b_count     <= '0;
      sat         <= 1'b0;
`ifdef COLOR_SENSE_HYST_EN
      prev_raw    <= COLOR_NONE;
`endif
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      ecnt        <= ecnt_nxt;
      sat_acc     <= sat_acc_nxt;
      // Registered from the next state so s2/s3 are glitch-free and line up
      // exactly with the state they belong to.
      filt        <= filter_for(state_nxt);
      color_valid <= (state == ST_DECIDE);

      if (in_meas && phase_last) begin
        case (state)
          ST_MEAS_R: stage_r <= ecnt_add;
          ST_MEAS_G: stage_g <= ecnt_add;
          default:   stage_b <= ecnt_add;
        endcase
      end

      if (state == ST_DECIDE) begin
        r_count <= stage_r;
        g_count <= stage_g;
        b_count <= stage_b;
        sat     <= sat_acc;
`ifdef COLOR_SENSE_HYST_EN
        prev_raw <= dec_color;
        if (dec_color == prev_raw) color_q <= dec_color;
`else
        color_q <= dec_color;
`endif
      end
    end
  end

  assign s2    = filt.s2;
  assign s3    = filt.s3;
  assign color = color_q;

endmodule

// File: tb/tb_color_sense_multi.sv
// ---------------------------------------------------------------------------
// tb_color_sense_multi
// Drives two instances side by side from one sensor waveform: dut_a with the
// default parameters and dut_b with a 6-bit counter and upper band 60 so it
// clamps. The stimulus driver records every rising edge it puts on c_out and,
// knowing the frame timing, works out which measurement window each edge
// lands in after the two synchroniser stages. At frame end it pushes the
// expected counts, saturation, colour and publish cycle for each instance;
// independent monitors pop and compare whenever color_valid is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_color_sense_multi;

  localparam int WINDOW = 300;
  localparam int SETTLE = 4;
  localparam int PHASE  = SETTLE + WINDOW;
  localparam int FRAME  = 2 + 3 * PHASE;
  localparam int LO     = 25;
  localparam int CW_A   = 9;
  localparam int CW_B   = 6;
  localparam int HI_A   = 120;
  localparam int HI_B   = 60;

  typedef struct {
    int          cnt[3];
    int          color;
    int          sat;
    int unsigned at;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            c_out = 1'b0;

  logic            a_s2, a_s3, a_valid, a_sat;
  logic [2:0]      a_color;
  logic [CW_A-1:0] a_r, a_g, a_b;
  logic            b_s2, b_s3, b_valid, b_sat;
  logic [2:0]      b_color;
  logic [CW_B-1:0] b_r, b_g, b_b;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          held[2];
  int          prev[2];
  int          cw_of[2] = '{CW_A, CW_B};
  int          hi_of[2] = '{HI_A, HI_B};

  color_sense_multi #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .c_out(c_out), .s2(a_s2), .s3(a_s3),
    .color(a_color), .color_valid(a_valid), .r_count(a_r), .g_count(a_g),
    .b_count(a_b), .sat(a_sat)
  );

  color_sense_multi #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(CW_B),
                      .R_HI(HI_B), .G_HI(HI_B), .B_HI(HI_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .c_out(c_out), .s2(b_s2), .s3(b_s3),
    .color(b_color), .color_valid(b_valid), .r_count(b_r), .g_count(b_g),
    .b_count(b_b), .sat(b_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference classification from the rules: clamp, band test, largest wins,
  // earlier channel wins ties, optional two-frame agreement.
  function automatic exp_t model_frame(input int d, input int rises[3], input int unsigned at);
    exp_t e;
    int   mx;
    int   raw;
    int   bc;
    mx    = (1 << cw_of[d]) - 1;
    e.sat = 0;
    raw   = 0;
    bc    = -1;
    for (int k = 0; k < 3; k++) begin
      e.cnt[k] = (rises[k] > mx) ? mx : rises[k];
      if (rises[k] > mx) e.sat = 1;
      if (e.cnt[k] > LO && e.cnt[k] < hi_of[d] && e.cnt[k] > bc) begin
        raw = k + 1;
        bc  = e.cnt[k];
      end
    end
`ifdef COLOR_SENSE_HYST_EN
    if (raw == prev[d]) held[d] = raw;
    prev[d] = raw;
`else
    held[d] = raw;
`endif
    e.color = held[d];
    e.at    = at;
    return e;
  endfunction

  task automatic check_reset_outputs();
    check("rst.a_color", int'(a_color), 0);
    check("rst.a_valid", int'(a_valid), 0);
    check("rst.a_counts", int'(a_r) + int'(a_g) + int'(a_b), 0);
    check("rst.a_sat", int'(a_sat), 0);
    check("rst.a_filter", int'({a_s2, a_s3}), 2);
    check("rst.b_color", int'(b_color), 0);
    check("rst.b_counts", int'(b_r) + int'(b_g) + int'(b_b), 0);
    check("rst.b_sat", int'(b_sat), 0);
  endtask

  // Runs one frame starting at the negedge of its IDLE cycle (offset 0).
  // drop_at: offset at which en is released; abort_at: offset at which reset
  // is asserted (frame abandoned). Use -1 to disable either.
  task automatic run_frame(input int pr, input int pg, input int pb,
                           input int drop_at, input int abort_at);
    int per[3];
    int rises[3];
    int ph;
    int ch;
    int last_ch;
    int st;
    logic nv;
    exp_t e;
    per     = '{pr, pg, pb};
    rises   = '{0, 0, 0};
    ph      = 0;
    last_ch = 0;
    for (int j = 0; j < FRAME; j++) begin
      if (j == abort_at) begin
        rst_n = 1'b0;
        c_out = 1'b0;
        held  = '{0, 0};
        prev  = '{0, 0};
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (j == drop_at) en = 1'b0;
      ch = (j + 1) / PHASE;
      if (ch > 2) ch = 2;
      if (ch != last_ch) ph = 0;
      last_ch = ch;
      nv = ((ph % per[ch]) < (per[ch] / 2)) ? 1'b0 : 1'b1;
      ph++;
      // A rise driven now reaches the counter two cycles later.
      if (nv && !c_out) begin
        for (int k = 0; k < 3; k++) begin
          st = 1 + k * PHASE + SETTLE;
          if (j + 2 >= st && j + 2 <= st + WINDOW - 1) rises[k]++;
        end
      end
      c_out = nv;
      if (j == 0) check("filter.idle", int'({a_s2, a_s3}), 2);
      for (int k = 0; k < 3; k++) begin
        if (j == 1 + k * PHASE || j == k * PHASE + PHASE) begin
          check($sformatf("filter.ch%0d", k), int'({a_s2, a_s3}), (k == 0) ? 0 : (k == 1) ? 3 : 1);
          check($sformatf("filter_b.ch%0d", k), int'({b_s2, b_s3}), (k == 0) ? 0 : (k == 1) ? 3 : 1);
        end
      end
      if (j == FRAME / 2) begin
        check("hold.a_color", int'(a_color), held[0]);
        check("hold.b_color", int'(b_color), held[1]);
      end
      if (j == FRAME - 1) begin
        e = model_frame(0, rises, cyc + 1);
        q_a.push_back(e);
        e = model_frame(1, rises, cyc + 1);
        q_b.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_valid) begin
      if (q_a.size() == 0) begin
        check("a.unexpected_valid", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("a.latency", int'(cyc), int'(e.at));
        check("a.r_count", int'(a_r), e.cnt[0]);
        check("a.g_count", int'(a_g), e.cnt[1]);
        check("a.b_count", int'(a_b), e.cnt[2]);
        check("a.sat", int'(a_sat), e.sat);
        check("a.color", int'(a_color), e.color);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_valid) begin
      if (q_b.size() == 0) begin
        check("b.unexpected_valid", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("b.latency", int'(cyc), int'(e.at));
        check("b.r_count", int'(b_r), e.cnt[0]);
        check("b.g_count", int'(b_g), e.cnt[1]);
        check("b.b_count", int'(b_b), e.cnt[2]);
        check("b.sat", int'(b_sat), e.sat);
        check("b.color", int'(b_color), e.color);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    held = '{0, 0};
    prev = '{0, 0};
    repeat (4) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    en    = 1'b1;

    run_frame(8, 4, 40, -1, -1);   // green wins
    run_frame(2, 2, 2, -1, -1);    // 150 each: out of band; dut_b clamps
    run_frame(5, 30, 5, -1, -1);   // red/blue tie at 60
    run_frame(8, 40, 40, -1, -1);  // red
    run_frame(40, 40, 8, -1, -1);  // blue
    run_frame(40, 40, 8, -1, -1);  // blue again
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(2, 40)), int'($urandom_range(2, 40)),
                int'($urandom_range(2, 40)), -1, -1);
    run_frame(8, 4, 40, -1, 1 + PHASE + SETTLE + 100);  // reset during MEAS_G
    run_frame(8, 4, 40, -1, -1);
    run_frame(6, 9, 12, 500, -1);  // en released mid-frame

    for (int i = 0; i < 700; i++) begin
      c_out = (i % 4) >= 2;
      @(negedge clk);
    end
    check("idle.filter", int'({a_s2, a_s3}), 2);
    check("pending.a", q_a.size(), 0);
    check("pending.b", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
